// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the HI/LO pair: WIDTH shift-add / restoring-divide steps, then sign fixup and a single write pulse.
// Optional MULDIV_EARLY_TERM_EN ends multiplies once the remaining multiplier bits are all zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_hilo_write,
    output logic [WIDTH-1:0] o_hi_out,
    output logic [WIDTH-1:0] o_lo_out,
    output logic             o_div_zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_divz;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_idle_or_done;
    logic               w_accept;
    logic               w_last;
    logic               w_early;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_mul_run;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_signed       = ~i_op[0];
    assign w_a_neg        = w_signed & i_operand_a[WIDTH-1];
    assign w_b_neg        = w_signed & i_operand_b[WIDTH-1];
    assign w_a_abs        = w_a_neg ? -i_operand_a : i_operand_a;
    assign w_b_abs        = w_b_neg ? -i_operand_b : i_operand_b;
    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept       = i_start & ~i_flush & w_idle_or_done;

    // Multiply step: acc low half holds the not-yet-consumed multiplier bits.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: the 33-bit trial keeps the bit shifted out of rem.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_opd};
    assign w_div_nxt = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_TERM_EN
    logic [CNT_W-1:0] w_rem_bits;
    logic [WIDTH-1:0] w_mask;
    assign w_rem_bits = r_cnt - CNT_W'(1);
    assign w_mask     = (WIDTH'(1) << w_rem_bits) - WIDTH'(1);
    assign w_early    = ~r_is_div & ((w_mul_nxt[WIDTH-1:0] & w_mask) == {WIDTH{1'b0}});
    assign w_mul_run  = w_early ? (w_mul_nxt >> w_rem_bits) : w_mul_nxt;
`else
    assign w_early    = 1'b0;
    assign w_mul_run  = w_mul_nxt;
`endif

    assign w_last     = (r_cnt == CNT_W'(1)) | w_early;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_fix_lo   = r_is_div ? (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0])
                                 : w_prod_fix[WIDTH-1:0];
    assign w_fix_hi   = r_is_div ? (r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH])
                                 : w_prod_fix[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_cnt    <= '0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= r_is_div ? w_div_nxt : w_mul_run;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_last) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= w_accept ? S_RUN : S_IDLE;
                    r_busy  <= w_accept;
                end
            endcase
            // Operand capture is shared by the IDLE and back-to-back DONE issue paths.
            if (w_accept) begin
                r_is_div <= i_op[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_divz   <= i_op[1] & (i_operand_b == {WIDTH{1'b0}});
                r_opd    <= i_op[1] ? w_b_abs : w_a_abs;
                r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_abs : w_b_abs)};
                r_cnt    <= CNT_W'(WIDTH);
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = (r_state == S_DONE);
    assign o_hilo_write = (r_state == S_DONE);
    assign o_div_zero   = (r_state == S_DONE) & r_divz;
    assign o_hi_out     = r_hi;
    assign o_lo_out     = r_lo;
    assign o_stall      = r_busy | (i_start & w_idle_or_done);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table for results/latency, hand sequences for flush, back-to-back, reset.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        stall, busy, done, hw, dz;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_operand_a(a), .i_operand_b(b), .i_flush(flush),
        .o_stall(stall), .o_busy(busy), .o_done(done), .o_hilo_write(hw),
        .o_hi_out(hi), .o_lo_out(lo), .o_div_zero(dz)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          lat_et;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op in cycle 0 and waits up to 60 cycles for Done (sampled on negedge).
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdz, output logic rhw, output logic stall_all);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        stall_all = stall;
        lat = -1; rhi = 'x; rlo = 'x; rdz = 'x; rhw = 'x;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c; rhi = hi; rlo = lo; rdz = dz; rhw = hw;
                break;
            end
            stall_all = stall_all & stall;
            @(posedge clk); #1;
        end
    endtask

    initial begin : main
        int          lat, exp_lat, first_done, second_done;
        logic [31:0] rhi, rlo, prev_hi, prev_lo;
        logic        rdz, rhw, sall, any_done;

        //            op     A             B             HI            LO            DZ  lat et
        tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 34};
        tbl[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 5};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 34};
        tbl[3]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 34, 34};
        tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 34};
        tbl[5]  = '{2'b01, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0, 34, 4};
        tbl[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 34};
        tbl[7]  = '{2'b00, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 1'b0, 34, 4};
        tbl[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 34, 34};
        tbl[9]  = '{2'b00, 32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        1'b0, 34, 3};
        tbl[10] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 34, 34};
        tbl[11] = '{2'b01, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0, 34, 7};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hw",   64'(hw),   64'(0));
        check("rst_dz",   64'(dz),   64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_hilo", {hi, lo}, 64'(0));

        for (int i = 0; i < 12; i++) begin
`ifdef MULDIV_EARLY_TERM_EN
            exp_lat = tbl[i].lat_et;
`else
            exp_lat = tbl[i].lat;
`endif
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, rhi, rlo, rdz, rhw, sall);
            check($sformatf("v%0d_lat", i),   64'(lat), 64'(exp_lat));
            check($sformatf("v%0d_hi", i),    64'(rhi), 64'(tbl[i].hi));
            check($sformatf("v%0d_lo", i),    64'(rlo), 64'(tbl[i].lo));
            check($sformatf("v%0d_dz", i),    64'(rdz), 64'(tbl[i].dz));
            check($sformatf("v%0d_hw", i),    64'(rhw), 64'(1));
            check($sformatf("v%0d_stall", i), 64'(sall), 64'(1));
        end
        prev_hi = tbl[11].hi;
        prev_lo = tbl[11].lo;

        // Flush at cycle 10 of DIVU 100/7, reissue at cycle 12.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        any_done = 1'b0;
        second_done = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            start = (c == 12);
            flush = (c == 10);
            @(negedge clk);
            if (c <= 11) any_done = any_done | done | hw;
            if (c == 11) begin
                check("fl_busy", 64'(busy), 64'(0));
                check("fl_keep", {hi, lo}, {prev_hi, prev_lo});
            end
            if (done && second_done < 0) begin
                second_done = c;
                check("fl_hi", 64'(hi), 64'(2));
                check("fl_lo", 64'(lo), 64'(14));
            end
        end
        check("fl_nodone", 64'(any_done), 64'(0));
        check("fl_lat", 64'(second_done), 64'(46));

        // Back-to-back: ignored Start at cycle 5, real reissue in the DONE cycle.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        first_done = -1; second_done = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            start = (c == 5) || (c == 34);
            op = (c == 5) ? 2'b11 : 2'b11;
            a  = (c == 5) ? 32'd9 : 32'd100;
            b  = (c == 5) ? 32'd3 : 32'd7;
            @(negedge clk);
            if (c == 34) check("b2b_stall", 64'(stall), 64'(1));
            if (done) begin
                if (first_done < 0) begin
                    first_done = c;
                    check("b2b_hilo1", {hi, lo}, 64'hFFFFFFFE_00000001);
                end else if (second_done < 0) begin
                    second_done = c;
                    check("b2b_hilo2", {hi, lo}, {32'd2, 32'd14});
                end
            end
        end
        start = 1'b0;
        check("b2b_first", 64'(first_done), 64'(34));
        check("b2b_second", 64'(second_done), 64'(68));

        // Flush and Start together in IDLE: not accepted.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd3;
        @(negedge clk);
        check("fs_stall", 64'(stall), 64'(1));
        any_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
            @(negedge clk);
            if (c == 1) check("fs_busy", 64'(busy), 64'(0));
            any_done = any_done | done;
        end
        check("fs_nodone", 64'(any_done), 64'(0));

        // Reset in the middle of RUN: no write, HI/LO cleared.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd3;
        any_done = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst = (c == 2);
            @(negedge clk);
            if (c == 3) begin
                check("mr_busy", 64'(busy), 64'(0));
                check("mr_hilo", {hi, lo}, 64'(0));
            end
            if (c >= 3) any_done = any_done | done | hw;
        end
        check("mr_nodone", 64'(any_done), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide engine and controller for the HI/LO register pair, driven from the EX stage.
- On a MULT/MULTU/DIV/DIVU issue it captures both operands and runs a 32-step shift-add or restoring-divide loop.
- It holds the pipeline with a stall output while running, then issues a single HI/LO write pulse with the 64-bit result.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  issue request from EX, qualified by the mult/div decode.
- Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  input  WIDTH  rs value: multiplicand or dividend.
- OperandB  input  WIDTH  rt value: multiplier or divisor.
- Flush  input  1  abort the current operation, for example on a branch or jump squash.
- Stall  output  1  freezes the IF/DEC/EX pipeline registers.
- Busy  output  1  registered; high while in the RUN or FIX state.
- Done  output  1  one-cycle pulse when the result is valid.
- HiLoWrite  output  1  write enable to HI and LO; same timing as Done.
- HiOut  output  WIDTH  high result word: product[63:32] or remainder.
- LoOut  output  WIDTH  low result word: product[31:0] or quotient.
- DivZero  output  1  high together with Done when a DIV/DIVU had a divisor of 0.

Behaviour:
- Reset (Rst=1 at a clock edge):
  - state goes to IDLE.
  - Busy, Done, HiLoWrite and DivZero are 0.
  - HiOut and LoOut are 0; the counter is 0.
- States are IDLE, RUN, FIX and DONE.
- IDLE:
  - Start=1 latches Op, the operands, the result sign and the remainder sign, then moves to RUN.
  - For signed ops the operands are latched as absolute values.
  - The counter loads WIDTH.
- RUN:
  - Performs one iteration per cycle and decrements the counter.
  - Multiply: if the accumulator LSB is 1, add the multiplicand to the upper half, then shift the {carry, acc} value right by 1.
  - Divide (restoring): shift {rem, quo} left by 1, trial-subtract the divisor, and keep the result if it is non-negative (setting quo LSB = 1).
  - When the counter reaches 1, move to FIX.
- FIX:
  - For signed ops, negate the 64-bit product if the sign is 1.
  - For signed ops, negate the quotient if sign(A) XOR sign(B), and give the remainder the sign of A.
  - Move to DONE.
- DONE:
  - HiOut and LoOut are updated, and Done=HiLoWrite=1 for exactly this cycle.
  - If Start=1 in this cycle, the new operation is accepted and the next state is RUN (back-to-back issue); otherwise the next state is IDLE.
- Latency:
  - Start sampled in cycle 0 gives Done in cycle WIDTH+2, which is cycle 34 at the default.
  - Busy is high in cycles 1..WIDTH+1.
- Stall = Busy OR (Start AND state in {IDLE, DONE}). It is combinational, so the issuing instruction is held from its own cycle onward.
- Start while in RUN or FIX is ignored. No queueing.
- Flush in RUN or FIX: next state is IDLE, no Done or HiLoWrite pulse, and HiOut/LoOut keep their previous values.
- Flush in DONE does not suppress the write.
- Flush and Start in the same IDLE cycle: Flush wins and the operation is not accepted.
- Divide by zero:
  - The operation runs the full latency.
  - Result is LoOut = all ones and HiOut = dividend (signed fixup applied per the rules above), with DivZero=1.
- Signed overflow case 0x80000000 / -1 gives Lo=0x80000000 and Hi=0; no trap.
- Rst in any state overrides everything and returns to IDLE next cycle with no write.
- HiOut and LoOut change only in DONE or on reset.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: for MULT/MULTU only, RUN exits to FIX when the unconsumed multiplier bits are all zero, with the remaining shift applied in one step.
  - Minimum is 1 RUN cycle, so Done arrives no earlier than cycle 3.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH RUN cycles for every op.

Test Plan:
- Rst, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done at cycle 34; Hi=0xFFFFFFFE, Lo=0x00000001; Stall high in cycles 0..33.
- MULT A=-3 (0xFFFFFFFD), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21). DIV A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIVU A=100 B=0 -> Done at cycle 34 with DivZero=1, Lo=0xFFFFFFFF, Hi=100.
- DIVU 100/7 issued, Flush at cycle 10 -> no Done/HiLoWrite; Hi/Lo retain prior values; Busy=0 by cycle 11. A new Start at cycle 12 completes at cycle 46 with Lo=14, Hi=2.
- Back-to-back: second Start in the DONE cycle of the first op -> first write occurs, second Done 34 cycles later. A Start asserted at cycle 5 (in RUN) is ignored.
- With MULDIV_EARLY_TERM_EN: MULTU A=5 B=3 -> Done at cycle ≤5, Hi=0, Lo=15. Without the macro -> Done at cycle 34 with the same result.
